// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - walks a register file read port and streams every value with an XOR checksum
// Optional build macro: REGFILE_DUMP_SKIP_ZERO_EN (skip hardwired-zero r0, dump starts at index 1)
module regfile_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

`ifdef REGFILE_DUMP_SKIP_ZERO_EN
  localparam logic [ADDR_W-1:0] START_IDX = ADDR_W'(1);
`else
  localparam logic [ADDR_W-1:0] START_IDX = ADDR_W'(0);
`endif

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] idx;
  logic              handshake;
  logic              at_last;

  assign handshake = (state == SEND) && out_ready;
  assign at_last   = (idx == LAST_IDX);

  // The read port address comes straight from the index register, so it is
  // glitch-free and stable for the whole FETCH cycle and while stalled in SEND.
  assign rf_addr = idx;

  // State register; reset drops the FSM to IDLE immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; the terminal compare happens before any increment.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   state_nxt = SEND;
      SEND:    if (handshake) state_nxt = at_last ? DONE : FETCH;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from state so they follow an async reset at once.
  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE:    busy = 1'b0;
      FETCH:   ;
      SEND:    out_valid = 1'b1;
      DONE:    done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Walk index: loaded on an accepted start, advanced only after a non-final handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (state == IDLE && start) begin
      idx <= START_IDX;
    end else if (handshake && !at_last) begin
      idx <= idx + ADDR_W'(1);
    end
  end

  // Capture the word and its index in FETCH; held through SEND while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_index <= '0;
    end else if (state == FETCH) begin
      out_data  <= rf_data;
      out_index <= idx;
    end
  end

  // Running XOR of every captured word; cleared on start, held after DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum <= '0;
    end else if (state == IDLE && start) begin
      checksum <= '0;
    end else if (state == FETCH) begin
      checksum <= checksum ^ rf_data;
    end
  end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
Debug read-out engine that sits on one combinational read port of the 32x32 register file (address out, data in). On a start pulse it walks the register indices in order and streams each value out over a valid/ready handshake. At the end it reports a running XOR checksum. It is used by the debug/trace path to dump architectural state without stalling the write port.

Parameters:
NUM_REGS, 32, number of registers walked; last index is NUM_REGS-1
ADDR_W, 5, width of the register index; must satisfy 2**ADDR_W >= NUM_REGS
DATA_W, 32, register data width

Ports:
clk  in  1  system clock; all state updates on posedge
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle request to begin a dump; sampled only in IDLE
rf_addr  out  ADDR_W  address driven to the register-file read port
rf_data  in  DATA_W  combinational read data for rf_addr
out_valid  out  1  out_data/out_index hold a valid word
out_ready  in  1  consumer accepts the word when out_valid && out_ready
out_data  out  DATA_W  captured register value
out_index  out  ADDR_W  register index of out_data
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after the last word is accepted
checksum  out  DATA_W  XOR of all words sent in the current or last dump; valid when done=1, held until next start

Behaviour:
- Reset (async, rst=1): state=IDLE; idx, rf_addr, out_data, out_index, checksum=0; out_valid, busy, done=0. out_valid falls immediately, not at the next clock edge.
- FSM states: IDLE, FETCH, SEND, DONE.
- IDLE: busy=0. On start=1: idx<=START_IDX (0, or 1 with the option below), checksum<=0, go to FETCH.
- FETCH, one cycle: rf_addr=idx (registered, stable the whole cycle). At the clock edge: out_data<=rf_data, out_index<=idx, checksum<=checksum^rf_data, go to SEND.
- SEND: out_valid=1. out_data, out_index and rf_addr hold stable while out_ready=0; there is no timeout.
- SEND, on handshake: if idx==NUM_REGS-1, go to DONE; else idx<=idx+1 and go to FETCH. out_valid drops in the cycle after the handshake.
- DONE, one cycle: done=1, then go to IDLE. checksum is held after DONE.
- Latency: start sampled at edge N gives out_valid=1 from cycle N+2. Peak throughput is 1 word per 2 cycles. A full dump with out_ready tied to 1 takes 2*count+1 cycles from the start edge to the done pulse.
- start while busy=1 is ignored, with no restart and no queuing. start in the DONE cycle is also ignored.
- idx never wraps: the terminal compare happens before the increment, and no index >= NUM_REGS is ever driven on rf_addr.
- Register-file writes during a dump are not blocked. Each word reflects the register value at its own FETCH cycle.
- rst asserted mid-dump aborts the dump: all outputs return to reset values and no done pulse is produced.

Optional Feature:
REGFILE_DUMP_SKIP_ZERO_EN
- Defined: START_IDX=1. Register 0 (hardwired zero) is not fetched or sent, giving NUM_REGS-1 words per dump. The checksum excludes r0.
- Undefined: START_IDX=0. All NUM_REGS words are sent, starting with r0=0x00000000.

Test Plan:
- Reset: preload rN=N*0x01010101, assert rst mid-cycle -> out_valid, busy, done, out_data, checksum all 0 immediately. After release, FSM is in IDLE.
- Full dump, out_ready=1, option off: start pulse -> 32 words out_index 0..31 with out_data=N*0x01010101; out_valid first seen 2 cycles after start; done pulse 65 cycles after the start edge; checksum=XOR of all 32 values.
- Backpressure: hold out_ready=0 for 5 cycles on index 7 -> out_data=0x07070707 and out_index=7 stable throughout, no index skipped or duplicated.
- start while busy: pulse start at index 10 -> ignored, dump still ends at index 31 with a single done pulse. Re-pulse start after done -> a fresh dump with checksum restarted from 0.
- Mid-dump reset: assert rst after index 12 is accepted -> no done pulse. A new start after release begins again at index 0.
- REGFILE_DUMP_SKIP_ZERO_EN defined: start -> first out_index=1, 31 words total, done 63 cycles after the start edge, checksum excludes r0.
